stbl_monitor: RTL

Synthesizable stability checker that watches a data bus qualified by a flag and reports, as event records, whether the data held steady while the flag was active. It sits directly upstream of the bench's event logger: the bench pops one record per accepted handshake and writes it to `events.log` as an `ASSERT_STBL` line, so on-chip or emulated designs can produce the same log content as the software stability assertion.

---
 rtl/stbl_monitor_pkg.sv | 40 ++++
 rtl/stbl_monitor_if.sv | 33 +++
 rtl/stbl_monitor_event_fifo.sv | 80 ++++++++
 rtl/stbl_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stbl_monitor_pkg.sv
// Shared types for the stability monitor: log tone encoding, FSM states and
// the event record layout used by stbl_monitor and its event queue.
package verb_mon_pkg;

    // Log levels; numeric values match the bench logger's level encoding.
    typedef enum logic [2:0] {
        TRACE = 3'd0,
        DEBUG = 3'd1,
        INFO  = 3'd2,
        WARN  = 3'd3,
        ERROR = 3'd4,
        FATAL = 3'd5
    } tone_t;

    // Stability tracker states.
    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        BROKEN
    } stbl_state_t;

    // Default bus widths for the reference record layout below.
    localparam int STBL_DATA_W = 8;
    localparam int STBL_CNT_W  = 16;

    // Event record at the default widths. Modules with other widths declare a
    // local struct with the same field order so the packed words line up.
    typedef struct packed {
        tone_t                   level;
        logic [STBL_DATA_W-1:0]  dataOld;
        logic [STBL_DATA_W-1:0]  dataNew;
        logic [STBL_CNT_W-1:0]   cycles;
    } stbl_evt_t;

    // Packed width of an event record for a given data and counter width.
    function automatic int stblEvtWidth(input int dw, input int cw);
        return $bits(tone_t) + 2 * dw + cw;
    endfunction

endpackage

// File: rtl/stbl_monitor_if.sv
// Event record handshake between the stability monitor (master) and the
// record consumer (slave). Valid/ready: a record moves when both are high.
interface stbl_monitor_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);

    logic                  evt_valid;
    logic                  evt_ready;
    logic [2:0]            evt_level;
    logic [DATA_WIDTH-1:0] evt_data_old;
    logic [DATA_WIDTH-1:0] evt_data_new;
    logic [CNT_WIDTH-1:0]  evt_cycles;

    modport master (
        output evt_valid,
        output evt_level,
        output evt_data_old,
        output evt_data_new,
        output evt_cycles,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_level,
        input  evt_data_old,
        input  evt_data_new,
        input  evt_cycles,
        output evt_ready
    );

endinterface

// File: rtl/stbl_monitor_event_fifo.sv
// Generic synchronous FIFO with a registered head word and full/empty flags.
// A push while full is accepted only when a pop happens on the same edge;
// a pop while empty is ignored.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;

    // Accept decisions, pointer/count updates and the next head word.
    always_comb begin
        doPop   = pop_i && !empty_o;
        doPush  = push_i && (!full_o || doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
        // The new head is the incoming word when it lands in the head slot.
        if (doPush && (wrPtr_q == rdPtr_d)) begin
            head_d = pushData_i;
        end else begin
            head_d = mem_q[rdPtr_d];
        end
    end

    // Storage, pointers and head register; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/stbl_monitor.sv
// Stability monitor: while flag is active the data bus must not change.
// Each tracking window yields one INFO record (data held) or one ERROR
// record (first change seen), queued for a valid/ready consumer.
// Optional feature: define STBL_MONITOR_DROP_CNT_EN to add the drop_cnt
// output counting events lost to a full queue.
module stbl_monitor
    import verb_mon_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   CNT_WIDTH  = 16,
    parameter int   FIFO_DEPTH = 4,
    parameter logic ACTIVE     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flag,
    input  logic [DATA_WIDTH-1:0] data,
    stbl_monitor_if.master        evt,
    output logic                  overflow
`ifdef STBL_MONITOR_DROP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  drop_cnt
`endif
);

    typedef struct packed {
        tone_t                  level;
        logic [DATA_WIDTH-1:0]  dataOld;
        logic [DATA_WIDTH-1:0]  dataNew;
        logic [CNT_WIDTH-1:0]   cycles;
    } evtRec_t;

    localparam int EVT_W = stblEvtWidth(DATA_WIDTH, CNT_WIDTH);

    stbl_state_t           state_q;
    logic                  primed_q;
    logic                  lastFlag_q;
    logic [DATA_WIDTH-1:0] lastData_q;
    logic [CNT_WIDTH-1:0]  cycles_q;
    logic [CNT_WIDTH-1:0]  cyclesInc;
    logic                  overflow_q;
    logic                  flagActive;
    logic                  pushReq;
    evtRec_t               pushRec;
    logic                  popReq;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  drop;
    logic [EVT_W-1:0]      fifoHead;
    evtRec_t               headRec;

    assign flagActive = (flag == ACTIVE);
    assign cyclesInc  = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
    assign popReq     = !fifoEmpty && evt.evt_ready;
    assign drop       = pushReq && fifoFull && !popReq;

    // Decide whether this edge produces an event, and build its record.
    always_comb begin
        pushReq = 1'b0;
        pushRec = '0;
        if (state_q == TRACK) begin
            if (flagActive) begin
                if (data != lastData_q) begin
                    pushReq         = 1'b1;
                    pushRec.level   = ERROR;
                    pushRec.dataOld = lastData_q;
                    pushRec.dataNew = data;
                    pushRec.cycles  = cycles_q;
                end
            end else begin
                pushReq         = 1'b1;
                pushRec.level   = INFO;
                pushRec.dataOld = lastData_q;
                pushRec.dataNew = lastData_q;
                pushRec.cycles  = cycles_q;
            end
        end
    end

    // Tracking FSM: the first edge after reset only primes the history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            primed_q   <= 1'b0;
            lastFlag_q <= 1'b0;
            lastData_q <= '0;
            cycles_q   <= '0;
        end else begin
            primed_q   <= 1'b1;
            lastFlag_q <= flagActive;
            lastData_q <= data;
            if (primed_q) begin
                case (state_q)
                    IDLE: begin
                        if (!lastFlag_q && flagActive) begin
                            state_q  <= TRACK;
                            cycles_q <= CNT_WIDTH'(1);
                        end
                    end
                    TRACK: begin
                        if (flagActive) begin
                            cycles_q <= cyclesInc;
                            if (data != lastData_q) begin
                                state_q <= BROKEN;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    BROKEN: begin
                        if (flagActive) begin
                            cycles_q <= cyclesInc;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Sticky overflow flag: set whenever an event is lost to a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

`ifdef STBL_MONITOR_DROP_CNT_EN
    logic [CNT_WIDTH-1:0] dropCnt_q;

    // Saturating count of dropped events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropCnt_q <= '0;
        end else if (drop && !(&dropCnt_q)) begin
            dropCnt_q <= dropCnt_q + 1'b1;
        end
    end

    assign drop_cnt = dropCnt_q;
`endif

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (pushReq),
        .pushData_i (pushRec),
        .pop_i      (popReq),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .head_o     (fifoHead)
    );

    assign headRec          = evtRec_t'(fifoHead);
    assign evt.evt_valid    = !fifoEmpty;
    assign evt.evt_level    = headRec.level;
    assign evt.evt_data_old = headRec.dataOld;
    assign evt.evt_data_new = headRec.dataNew;
    assign evt.evt_cycles   = headRec.cycles;

endmodule
